alu_ctrl_exec: RTL

//  Second-generation ALU control plus execute stage for the RISC-V datapath.
//  - Decodes {funct7,funct3} (10 b) and the 2-bit ALUOp into a 4-bit ALU control code.
//  - Executes the decoded op on registered operands.
//  - ADD/SUB/AND/OR/shift complete in 1 cycle. MUL runs as an iterative shift-add over

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mul_iter.sv | 56 +++++
 rtl/alu_ctrl_exec.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control/execute stage: control codes, ALUOp values,
// funct10 encodings and the FSM state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    localparam logic [9:0] F10_ADD = 10'b0000000000;
    localparam logic [9:0] F10_SUB = 10'b0100000000;
    localparam logic [9:0] F10_AND = 10'b0000000111;
    localparam logic [9:0] F10_OR  = 10'b0000000110;
    localparam logic [9:0] F10_MUL = 10'b0000001000;
    localparam logic [9:0] F10_SLL = 10'b0000000001;
    localparam logic [9:0] F10_SRL = 10'b0000000101;
    localparam logic [9:0] F10_SRA = 10'b0100000101;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StOut
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_RADIX multiplier bits per cycle.
// product_o is combinational and is final in the cycle done_o is high.
module alu_mul_iter #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MUL_RADIX = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int unsigned Iters = XLEN / MUL_RADIX;
    localparam int unsigned CntW  = $clog2(Iters);

    logic [XLEN-1:0] a_q, b_q, acc_q, acc_next;
    logic [CntW-1:0] cnt_q;
    logic            busy_q;

    // Low XLEN bits of an unsigned product equal those of the signed product.
    always_comb begin
        acc_next = acc_q;
        for (int i = 0; i < int'(MUL_RADIX); i++) begin
            if (b_q[i]) acc_next = acc_next + (a_q << i);
        end
    end

    assign done_o    = busy_q && (cnt_q == CntW'(Iters - 1));
    assign product_o = acc_next;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            a_q   <= a_q << MUL_RADIX;
            b_q   <= b_q >> MUL_RADIX;
            acc_q <= acc_next;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_ctrl_exec.sv
// ALU control decode plus execute stage with valid/ready handshake and iterative MUL.
// Define ALU_SHIFT_EN to decode and build SLL/SRL/SRA.
module alu_ctrl_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MUL_RADIX = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [9:0]      funct_i,
    input  logic [1:0]      ALUOp_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [3:0]      ALUCtrl_o,
    output logic            illegal_o
);

    state_e          state_q, state_d;
    logic [3:0]      dec_code, ctrl_q;
    logic            dec_ill, illegal_q, is_mul, accept, mul_done;
    logic [XLEN-1:0] alu_res, result_q, mul_product;

    always_comb begin
        dec_code = ALU_ADD;
        dec_ill  = 1'b0;
        case (ALUOp_i)
            ALUOP_MEM: dec_code = ALU_ADD;
            ALUOP_BR:  dec_code = ALU_SUB;
            ALUOP_R: begin
                case (funct_i)
                    F10_ADD: dec_code = ALU_ADD;
                    F10_SUB: dec_code = ALU_SUB;
                    F10_AND: dec_code = ALU_AND;
                    F10_OR:  dec_code = ALU_OR;
                    F10_MUL: dec_code = ALU_MUL;
`ifdef ALU_SHIFT_EN
                    F10_SLL: dec_code = ALU_SLL;
                    F10_SRL: dec_code = ALU_SRL;
                    F10_SRA: dec_code = ALU_SRA;
`endif
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign is_mul = !dec_ill && (dec_code == ALU_MUL);

`ifdef ALU_SHIFT_EN
    localparam int unsigned ShW = $clog2(XLEN);
    logic [ShW-1:0] shamt;
    assign shamt = rs2_i[ShW-1:0];
`endif

    always_comb begin
        alu_res = '0;
        if (!dec_ill) begin
            case (dec_code)
                ALU_AND: alu_res = rs1_i & rs2_i;
                ALU_OR:  alu_res = rs1_i | rs2_i;
                ALU_ADD: alu_res = rs1_i + rs2_i;
                ALU_SUB: alu_res = rs1_i - rs2_i;
`ifdef ALU_SHIFT_EN
                ALU_SLL: alu_res = rs1_i << shamt;
                ALU_SRL: alu_res = rs1_i >> shamt;
                ALU_SRA: alu_res = $signed(rs1_i) >>> shamt;
`endif
                default: alu_res = '0;
            endcase
        end
    end

    alu_mul_iter #(
        .XLEN      (XLEN),
        .MUL_RADIX (MUL_RADIX)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (accept && is_mul),
        .a_i       (rs1_i),
        .b_i       (rs2_i),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = is_mul ? StMul : StOut;
            StMul:  if (mul_done) state_d = StOut;
            StOut: begin
                if (ready_i) begin
                    if (accept) state_d = is_mul ? StMul : StOut;
                    else        state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        valid_o = (state_q == StOut);
        ready_o = (state_q == StIdle) || ((state_q == StOut) && ready_i);
    end

    assign accept = valid_i && ready_o;

    // A MUL accept leaves result_q alone; it is loaded when the multiplier finishes.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            result_q  <= '0;
            ctrl_q    <= 4'b0000;
            illegal_q <= 1'b0;
        end else if (accept) begin
            ctrl_q    <= dec_code;
            illegal_q <= dec_ill;
            if (!is_mul) result_q <= alu_res;
        end else if ((state_q == StMul) && mul_done) begin
            result_q <= mul_product;
        end
    end

    assign result_o  = result_q;
    assign ALUCtrl_o = ctrl_q;
    assign illegal_o = illegal_q;

endmodule
